// File: rtl/fu_pkg.sv
// Shared functional-unit constants for the result collector slice: widths,
// reserved/no-completion ID, FU IDs and the round-robin pointer helper.
package fu_pkg;

    localparam int unsigned ID_W   = 4;
    localparam int unsigned DATA_W = 32;

    localparam logic [ID_W-1:0] FU_ID_NONE = '0;
    localparam logic [ID_W-1:0] FU_ID_ALU  = 4'd1;
    localparam logic [ID_W-1:0] FU_ID_MEM  = 4'd2;
    localparam logic [ID_W-1:0] FU_ID_MUL  = 4'd3;
    localparam logic [ID_W-1:0] FU_ID_DIV  = 4'd4;
    localparam logic [ID_W-1:0] FU_ID_JUMP = 4'd5;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 32'd0 : idx + 1;
    endfunction

endpackage

// File: rtl/fu_result_collector_if.sv
// FU completion inputs, busy back-pressure and the valid/ready writeback bus.
// master = collector side, slave = FUs / issue / register-file side.
interface fu_result_collector_if #(
    parameter int unsigned NUM_FU = 5,
    parameter int unsigned DATA_W = fu_pkg::DATA_W,
    parameter int unsigned ID_W   = fu_pkg::ID_W
);
    logic [NUM_FU*ID_W-1:0]   fu_finish;
    logic [NUM_FU*DATA_W-1:0] fu_res;
    logic [NUM_FU-1:0]        fu_busy;
    logic                     wb_valid;
    logic [ID_W-1:0]          wb_id;
    logic [DATA_W-1:0]        wb_data;
    logic                     wb_ready;
    logic                     overflow;

    modport master (
        input  fu_finish, fu_res, wb_ready,
        output fu_busy, wb_valid, wb_id, wb_data, overflow
    );

    modport slave (
        output fu_finish, fu_res, wb_ready,
        input  fu_busy, wb_valid, wb_id, wb_data, overflow
    );
endinterface

// File: rtl/fu_result_collector_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr,
// wrapping modulo N. Pointer state lives in the caller.
module rr_arbiter #(
    parameter int unsigned N     = 5,
    parameter int unsigned IDX_W = 3
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant_oh,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);
    always_comb begin : arb_scan
        int unsigned j;
        grant_oh  = '0;
        grant_idx = '0;
        j         = 0;
        for (int unsigned k = 0; k < N; k++) begin
            j = 32'(ptr) + k;
            if (j >= N) j = j - N;
            if (grant_oh == '0 && req[j]) begin
                grant_oh[j] = 1'b1;
                grant_idx   = IDX_W'(j);
            end
        end
    end

    assign any = |req;
endmodule

// File: rtl/fu_result_collector.sv
// Per-FU result holding slots with round-robin writeback and sticky overflow.
// Optional FU_COLLECT_BYPASS_EN: present a finisher in its own cycle when all slots are empty.
module fu_result_collector #(
    parameter int unsigned NUM_FU = 5,
    parameter int unsigned DATA_W = fu_pkg::DATA_W,
    parameter int unsigned ID_W   = fu_pkg::ID_W
) (
    input logic                   clk,
    input logic                   rst,
    fu_result_collector_if.master bus
);
    localparam int unsigned IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [NUM_FU-1:0] slot_valid;
    logic [ID_W-1:0]   slot_id   [NUM_FU];
    logic [DATA_W-1:0] slot_data [NUM_FU];
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  hold_idx;
    logic              hold_active;
    logic              overflow_q;

    logic [NUM_FU-1:0] fin_vec, slot_oh, sel_oh, drain_vec, cap_vec;
    logic [IDX_W-1:0]  slot_idx, sel_idx;
    logic              slot_any, byp_take, transfer, wb_valid_c;
    logic [ID_W-1:0]   wb_id_c;
    logic [DATA_W-1:0] wb_data_c;

    always_comb begin
        fin_vec = '0;
        for (int unsigned i = 0; i < NUM_FU; i++)
            fin_vec[i] = (bus.fu_finish[i*ID_W +: ID_W] != ID_W'(fu_pkg::FU_ID_NONE));
    end

    rr_arbiter #(.N(NUM_FU), .IDX_W(IDX_W)) u_slot_arb (
        .req       (slot_valid),
        .ptr       (rr_ptr),
        .grant_oh  (slot_oh),
        .grant_idx (slot_idx),
        .any       (slot_any)
    );

`ifdef FU_COLLECT_BYPASS_EN
    logic [NUM_FU-1:0] byp_oh;
    logic [IDX_W-1:0]  byp_idx;
    logic              byp_any;

    rr_arbiter #(.N(NUM_FU), .IDX_W(IDX_W)) u_byp_arb (
        .req       (fin_vec),
        .ptr       (rr_ptr),
        .grant_oh  (byp_oh),
        .grant_idx (byp_idx),
        .any       (byp_any)
    );
`endif

    // A stalled grant is pinned via hold_idx so later arrivals cannot preempt it.
    always_comb begin
        sel_oh     = slot_oh;
        sel_idx    = slot_idx;
        wb_valid_c = slot_any;
        byp_take   = 1'b0;
        if (hold_active) begin
            sel_oh           = '0;
            sel_oh[hold_idx] = 1'b1;
            sel_idx          = hold_idx;
            wb_valid_c       = 1'b1;
        end
`ifdef FU_COLLECT_BYPASS_EN
        else if (!slot_any && byp_any) begin
            sel_oh     = byp_oh;
            sel_idx    = byp_idx;
            wb_valid_c = 1'b1;
            byp_take   = 1'b1;
        end
`endif
        wb_id_c   = '0;
        wb_data_c = '0;
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            if (sel_oh[i]) begin
                if (byp_take) begin
                    wb_id_c   = bus.fu_finish[i*ID_W +: ID_W];
                    wb_data_c = bus.fu_res[i*DATA_W +: DATA_W];
                end else begin
                    wb_id_c   = slot_id[i];
                    wb_data_c = slot_data[i];
                end
            end
        end
    end

    assign transfer  = wb_valid_c & bus.wb_ready;
    assign drain_vec = sel_oh & {NUM_FU{transfer & ~byp_take}};
    // A bypassed result accepted this cycle never occupies its slot.
    assign cap_vec   = fin_vec & ~(sel_oh & {NUM_FU{transfer & byp_take}});

    assign bus.wb_valid = wb_valid_c;
    assign bus.wb_id    = wb_id_c;
    assign bus.wb_data  = wb_data_c;
    assign bus.fu_busy  = slot_valid;
    assign bus.overflow = overflow_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_valid  <= '0;
            rr_ptr      <= '0;
            hold_idx    <= '0;
            hold_active <= 1'b0;
            overflow_q  <= 1'b0;
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                slot_id[i]   <= '0;
                slot_data[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                if (cap_vec[i]) begin
                    if (!slot_valid[i] || drain_vec[i]) begin
                        slot_valid[i] <= 1'b1;
                        slot_id[i]    <= bus.fu_finish[i*ID_W +: ID_W];
                        slot_data[i]  <= bus.fu_res[i*DATA_W +: DATA_W];
                    end
                end else if (drain_vec[i]) begin
                    slot_valid[i] <= 1'b0;
                end
            end
            if (|(cap_vec & slot_valid & ~drain_vec))
                overflow_q <= 1'b1;
            if (transfer) begin
                rr_ptr      <= IDX_W'(fu_pkg::rr_next(32'(sel_idx), NUM_FU));
                hold_active <= 1'b0;
            end else if (wb_valid_c) begin
                hold_active <= 1'b1;
                hold_idx    <= sel_idx;
            end
        end
    end
endmodule

// File: doc/fu_result_collector.md
# fu_result_collector

Writeback-side consumer for the functional units' completion protocol: each FU pulses a nonzero 4-bit finish ID for one cycle with its 32-bit result on `res`. The collector captures every completion into a per-FU holding slot, arbitrates round-robin among pending slots, and presents one result per cycle on a valid/ready writeback bus feeding the register file and reservation-station wakeup. `fu_busy` back-pressures issue so an FU is not re-enabled while its previous result is undelivered.

## Interface
- `NUM_FU`, 5, number of attached functional units (2..8)
- `DATA_W`, 32, result width
- `ID_W`, 4, finish/FU ID width; ID 0 is reserved for "no completion"
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset; asynchronous, active-high
- `fu_finish`  in  NUM_FU*ID_W  per-FU finish ID, slice i = bits [i*ID_W +: ID_W]; nonzero = completion this cycle
- `fu_res`  in  NUM_FU*DATA_W  per-FU result, sampled only when the matching finish slice is nonzero
- `fu_busy`  out  NUM_FU  slot i holds an undelivered result; issue must not assert EN to FU i
- `wb_valid`  out  1  a result is presented
- `wb_id`  out  ID_W  finish ID of the presented result
- `wb_data`  out  DATA_W  presented result
- `wb_ready`  in  1  consumer accepts this cycle
- `overflow`  out  1  sticky: a completion was dropped

## Operation
- Per slot i: `valid_i`, `id_i`, `data_i`. Capture when `fu_finish[i] != 0`: load ID and data, set valid.
- Grant: first valid slot scanning from `rr_ptr` upward, wrapping modulo NUM_FU. `wb_*` are combinational from the granted slot; `wb_id`/`wb_data` are 0 when `wb_valid` = 0.
- Transfer = `wb_valid & wb_ready` at a rising edge: granted slot cleared, `rr_ptr <= (grant+1) mod NUM_FU`. With no transfer, `rr_ptr` holds.
- Simultaneous drain and capture on the same slot: new result loads, slot stays valid, no overflow.
- Capture into a slot that is valid and not drained this cycle: new result dropped, old result kept, `overflow` set until reset.
- Multiple FUs finishing in the same cycle all capture; no completion is lost while slots are free.
- `fu_busy[i] = valid_i`.
- Presentation stability: once `wb_valid` rises, `wb_id`/`wb_data` are held until transfer. Slots at or after `rr_ptr` that become valid later do not preempt a presented grant; the grant is registered as `hold_idx` while stalled.

## Timing
- Reset (async): all slots invalid, `rr_ptr` = 0, `overflow` = 0; hence `wb_valid` = 0, `wb_id` = 0, `wb_data` = 0, `fu_busy` = 0. A reset mid-operation discards all pending results.
- Latency without bypass: finish at cycle t gives `wb_valid` in cycle t+1; the earliest transfer is at the end of t+1.
- Throughput: one transfer per cycle.
- `fu_busy[i]` rises the cycle after capture and falls the cycle after transfer.

## Configuration
- `FU_COLLECT_BYPASS_EN` defined: when no slot is valid, the first finishing FU (round-robin order from `rr_ptr`) is presented on `wb_*` in the same cycle t.
  - If `wb_ready` = 1 it is not stored.
  - If `wb_ready` = 0 it is stored normally.
  - Other simultaneous finishers are stored.
- Undefined: all results pass through slots, with 1-cycle minimum latency.

## Structure
- Shared package `fu_pkg`: `ID_W`, `DATA_W`, reserved `FU_ID_NONE = 0`, FU ID constants (ALU = 1, MEM = 2, MUL = 3, DIV = 4, JUMP = 5).
- Sub-module `rr_arbiter`: NUM_FU request vector plus pointer, producing a one-hot grant and grant index. It is purely combinational; pointer update stays in the collector.

## Test plan
- Reset, then MUL (slot 2) finish ID 3, data 0x0000_0042, `wb_ready` = 1 -> next cycle `wb_valid` = 1, `wb_id` = 3, `wb_data` = 0x42; `fu_busy[2]` rises then clears.
- Slots 0, 2, 4 finish together (IDs 1, 3, 5), `wb_ready` = 1, `rr_ptr` = 0 -> transfers in order IDs 1, 3, 5 over three consecutive cycles; `rr_ptr` ends at 0.
- `wb_ready` = 0 for 4 cycles with slot 1 pending and slot 0 finishing later -> `wb_id` stays 2 and stable; after `wb_ready` goes high, ID 2 then ID 1 transfer.
- Slot 3 full, `wb_ready` = 0, second finish on slot 3 with data 0xBEEF -> `overflow` = 1; the delivered data is the original value.
- Slot 3 granted and transferring while FU 3 finishes again with 0x7 -> no overflow; 0x7 is delivered the next cycle.
- Assert `rst` with 3 pending slots -> all outputs 0 immediately (asynchronous); no stale results appear after release. With `FU_COLLECT_BYPASS_EN` defined: an empty collector with a finish and `wb_ready` = 1 -> same-cycle `wb_valid`, and `fu_busy` never rises.
